// File: rtl/free_addr_mgr.sv
// Free block address manager: a circular list of free addresses that is
// filled with 0..DEPTH-1 after reset, hands addresses out in FIFO order
// through a one-entry output register and takes released addresses back.
module free_addr_mgr #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LOW_TH = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  output logic [ADDR_W-1:0] oEptyAddr,
  output logic              oEptyAddrVld,
  input  logic              iEptyAddrRcvRdy,
  input  logic [ADDR_W-1:0] iRlsAddr,
  input  logic              iRlsAddrVld,
  output logic              oRlsAddrRdy,
  output logic [ADDR_W:0]   oFreeCnt,
  output logic              oLowWater,
  output logic              oInitDone
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FullCnt  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LowTh    = (ADDR_W + 1)'(LOW_TH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] r_rdptr;
  logic [ADDR_W-1:0] r_wrptr;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_vld;
  logic [ADDR_W:0]   r_free_cnt;

  logic              w_run;
  logic              w_alloc;
  logic              w_rls;
  logic              w_load;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_data;
  logic [ADDR_W:0]   w_sto_cnt;

  assign w_run     = (r_state == StRun);
  assign w_alloc   = r_out_vld & iEptyAddrRcvRdy;
  assign w_rls     = iRlsAddrVld & oRlsAddrRdy;
  // Entries still in the list, i.e. not counting the one on the output register.
  assign w_sto_cnt = r_free_cnt - (ADDR_W + 1)'(r_out_vld);
  // Refill the output register only from the list; a release never bypasses it.
  assign w_load    = w_run & (w_sto_cnt != '0) & (~r_out_vld | w_alloc);
  assign w_wr_en   = ~w_run | w_rls;
  assign w_wr_data = w_run ? iRlsAddr : r_init_cnt;

  assign oEptyAddr    = r_out_addr;
  assign oEptyAddrVld = r_out_vld;
  assign oRlsAddrRdy  = w_run & (r_free_cnt < FullCnt);
  assign oFreeCnt     = r_free_cnt;
  assign oLowWater    = (r_free_cnt <= LowTh);
  assign oInitDone    = w_run;

  // Next state: leave INIT once the last address has been written.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == StInit && r_init_cnt == LastAddr) begin
      w_state_nxt = StRun;
    end
  end

  // State register and init counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run) begin
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
    end
  end

  // List storage: init fill or released address at the write pointer.
  always_ff @(posedge iClk) begin
    if (w_wr_en) begin
      r_mem[r_wrptr] <= w_wr_data;
    end
  end

  // Pointers, output register and free count.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rdptr    <= '0;
      r_wrptr    <= '0;
      r_out_vld  <= 1'b0;
      r_out_addr <= '0;
      r_free_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        r_wrptr <= r_wrptr + ADDR_W'(1);
      end
      if (w_load) begin
        r_out_addr <= r_mem[r_rdptr];
        r_out_vld  <= 1'b1;
        r_rdptr    <= r_rdptr + ADDR_W'(1);
      end else if (w_alloc) begin
        r_out_vld <= 1'b0;
      end
      if (!w_run || (w_rls && !w_alloc)) begin
        r_free_cnt <= r_free_cnt + (ADDR_W + 1)'(1);
      end else if (w_alloc && !w_rls) begin
        r_free_cnt <= r_free_cnt - (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_free_addr_mgr.sv
// Directed and random checks of free_addr_mgr with ADDR_W=4, LOW_TH=3.
module tb_free_addr_mgr;

  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] empty_addr;
  logic          empty_vld;
  logic          rcv_rdy;
  logic [AW-1:0] rls_addr;
  logic          rls_vld;
  logic          rls_rdy;
  logic [AW:0]   free_cnt;
  logic          low_water;
  logic          init_done;

  int n_chk = 0;
  int n_err = 0;

  free_addr_mgr #(.ADDR_W(AW), .LOW_TH(LTH)) dut (
    .iClk           (clk),
    .iRst           (rst),
    .oEptyAddr      (empty_addr),
    .oEptyAddrVld   (empty_vld),
    .iEptyAddrRcvRdy(rcv_rdy),
    .iRlsAddr       (rls_addr),
    .iRlsAddrVld    (rls_vld),
    .oRlsAddrRdy    (rls_rdy),
    .oFreeCnt       (free_cnt),
    .oLowWater      (low_water),
    .oInitDone      (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vld"}, empty_vld, 0);
    check({tag, "_rls_rdy"}, rls_rdy, 0);
    check({tag, "_cnt"}, free_cnt, 0);
    check({tag, "_done"}, init_done, 0);
    check({tag, "_low"}, low_water, 1);
  endtask

  // Release reset and run through DEPTH init cycles.
  task automatic run_init(input string tag);
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i == DEPTH - 1) begin
        check({tag, "_done_early"}, init_done, 0);
        check({tag, "_vld_init"}, empty_vld, 0);
        check({tag, "_rls_rdy_init"}, rls_rdy, 0);
      end
    end
    check({tag, "_done"}, init_done, 1);
    check({tag, "_cnt_full"}, free_cnt, DEPTH);
    check({tag, "_vld_lag"}, empty_vld, 0);
  endtask

  logic [AW-1:0] q[$];
  logic [AW-1:0] held_q[$];
  logic          held[DEPTH];

  initial begin
    rst = 1'b1;
    rcv_rdy = 1'b0;
    rls_addr = '0;
    rls_vld = 1'b0;
    #1;
    step();
    step();
    check_reset_vals("rst");

    // Init, then drain the whole pool at one allocation per cycle.
    rcv_rdy = 1'b1;
    run_init("init");
    step();
    for (int k = 0; k < DEPTH; k++) begin
      check("drain_vld", empty_vld, 1);
      check("drain_addr", empty_addr, k);
      check("drain_cnt", free_cnt, DEPTH - k);
      check("drain_low", low_water, (DEPTH - k) <= LTH);
      step();
    end
    check("empty_vld", empty_vld, 0);
    check("empty_cnt", free_cnt, 0);
    check("empty_rls_rdy", rls_rdy, 1);

    // Release into an empty pool: no bypass, appears after the next edge.
    rls_addr = 4'h9;
    rls_vld = 1'b1;
    check("rls9_rdy", rls_rdy, 1);
    step();
    rls_vld = 1'b0;
    check("rls9_cnt", free_cnt, 1);
    check("rls9_vld_lat", empty_vld, 0);
    step();
    check("rls9_vld", empty_vld, 1);
    check("rls9_addr", empty_addr, 4'h9);
    check("rls9_cnt2", free_cnt, 1);
    step();
    check("rls9_taken_cnt", free_cnt, 0);
    check("rls9_taken_vld", empty_vld, 0);

    // Build five free entries, then stream allocate+release together.
    rcv_rdy = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      rls_addr = AW'(10 + i);
      rls_vld = 1'b1;
      step();
      q.push_back(AW'(10 + i));
    end
    rls_vld = 1'b0;
    check("five_cnt", free_cnt, 5);
    for (int i = 0; i < 10; i++) begin
      check("stream_vld", empty_vld, 1);
      check("stream_addr", empty_addr, q[0]);
      check("stream_cnt", free_cnt, 5);
      rcv_rdy = 1'b1;
      rls_addr = AW'(i);
      rls_vld = 1'b1;
      step();
      void'(q.pop_front());
      q.push_back(AW'(i));
    end
    rls_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("tail_addr", empty_addr, q[i]);
      check("tail_vld", empty_vld, 1);
      step();
    end
    check("tail_cnt", free_cnt, 0);

    // Full pool with no consumer: output holds, releases are refused.
    rcv_rdy = 1'b0;
    rst = 1'b1;
    step();
    check_reset_vals("rst2");
    run_init("reinit");
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_addr", empty_addr, 0);
      check("hold_vld", empty_vld, 1);
      check("hold_cnt", free_cnt, DEPTH);
      check("hold_rls_rdy", rls_rdy, 0);
    end
    rls_addr = 4'h5;
    rls_vld = 1'b1;
    step();
    rls_vld = 1'b0;
    check("full_rls_cnt", free_cnt, DEPTH);

    // Allocate 9, then reset mid-run with seven free.
    rcv_rdy = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("mid_cnt", free_cnt, 7);
    check("mid_addr", empty_addr, 9);
    rst = 1'b1;
    step();
    check_reset_vals("rst3");
    run_init("reinit2");
    step();
    check("reinit_first_vld", empty_vld, 1);
    check("reinit_first_addr", empty_addr, 0);

    // Random traffic against a FIFO model of the free list.
    q.delete();
    held_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(AW'(i));
      held[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic          do_alloc;
      logic          do_rls;
      logic [AW-1:0] a;
      logic [AW-1:0] r;
      int            idx;
      check("rnd_cnt", free_cnt, q.size());
      check("rnd_rls_rdy", rls_rdy, q.size() < DEPTH);
      check("rnd_low", low_water, q.size() <= LTH);
      check("rnd_vld_empty", empty_vld & (q.size() == 0), 0);
      if (empty_vld) check("rnd_addr", empty_addr, q[0]);
      rcv_rdy = 1'($urandom_range(0, 1));
      do_rls = 1'b0;
      idx = 0;
      r = '0;
      if (held_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, held_q.size() - 1);
        r = held_q[idx];
        do_rls = 1'b1;
      end
      rls_vld = do_rls;
      rls_addr = r;
      do_alloc = empty_vld & rcv_rdy;
      do_rls = do_rls & (q.size() < DEPTH);
      step();
      if (do_alloc) begin
        a = q.pop_front();
        check("rnd_dup", held[a], 0);
        held[a] = 1'b1;
        held_q.push_back(a);
      end
      if (do_rls) begin
        held[r] = 1'b0;
        held_q.delete(idx);
        q.push_back(r);
      end
    end
    rls_vld = 1'b0;
    check("rnd_end_cnt", free_cnt, q.size());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
